// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: keeps a PAT_W-bit shift window of valid beats, flags matches
// against a programmable pattern and keeps a saturating match count.
module serial_pattern_detector #(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x_i,
   input  logic             valid_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic             overlap_i,
   input  logic             clear_i,
   output logic [PAT_W-1:0] window_o,
   output logic             match_o,
   output logic [CNT_W-1:0] match_cnt_o,
   output logic             armed_o
);

   localparam int unsigned FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_ARMED = 1'b1
   } state_e;

   state_e             state_q;
   logic [PAT_W-1:0]   window_q;
   logic [FILL_W-1:0]  fill_q;
   logic               match_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [PAT_W-1:0]   window_d;
   logic [FILL_W-1:0]  fill_d;
   logic               complete_c;
   logic               hit_c;

   // Candidate window and match decision for the beat currently presented
   always_comb begin
      window_d   = {window_q[PAT_W-2:0], x_i};
      fill_d     = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      complete_c = (state_q == ST_ARMED) || (fill_d == FILL_FULL);
      hit_c      = valid_i && complete_c && (window_d == pattern_i);
   end

   // Window, fill count, FSM, match pulse and saturating counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_FILL;
         window_q <= '0;
         fill_q   <= '0;
         match_q  <= 1'b0;
         cnt_q    <= '0;
      end else if (clear_i) begin
         state_q  <= ST_FILL;
         window_q <= '0;
         fill_q   <= '0;
         match_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         match_q <= hit_c;
         if (valid_i) begin
            window_q <= window_d;
            if (hit_c && (cnt_q != {CNT_W{1'b1}})) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
            // Non-overlapping mode restarts the fill; the window itself is kept
            if (hit_c && !overlap_i) begin
               state_q <= ST_FILL;
               fill_q  <= '0;
            end else begin
               fill_q <= fill_d;
               if (fill_d == FILL_FULL) begin
                  state_q <= ST_ARMED;
               end
            end
         end
      end
   end

   assign window_o    = window_q;
   assign match_o     = match_q;
   assign match_cnt_o = cnt_q;
   assign armed_o     = (state_q == ST_ARMED);

endmodule
